instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the dual-port instruction ROM: it drives the ROM's fetch address port, consumes the returned instruction word and valid flag, and buffers fetched instructions with their PCs in a small FIFO. The FIFO feeds decode over a valid/ready handshake. The block supports branch/jump redirects that flush all buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 124 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM address port and buffers {pc, instr} in a FIFO toward decode. Instructions reach decode 2 cycles after issue.
// New fetches stop while buffered plus in-flight entries would exceed FIFO_DEPTH. A redirect flushes all state, and a missing mem_rvalid replays the fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          pending_q, pending_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   data_d [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic [31:0]   pc_d   [FIFO_DEPTH];

    logic          resp_ok, replay, credit, issue, push, pop;
    logic [CW:0]   inflight_now, inflight_next;

    assign inst_valid = (count_q != '0);
    assign inst_data  = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign mem_addr   = fetch_pc_q;
    assign mem_req    = mem_req_q;

    always_comb begin
        resp_ok      = pending_q && mem_rvalid && !redirect_valid;
        replay       = pending_q && !mem_rvalid && !redirect_valid;
        inflight_now = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
        credit       = inflight_now < DEPTH_W;
        issue        = !redirect_valid && !replay && credit;
        push         = resp_ok;
        pop          = inst_valid && inst_ready && !redirect_valid;

        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        data_d     = data_q;
        pc_d       = pc_q;

        if (redirect_valid) begin
            // Flush everything; the response arriving this cycle is dropped.
            fetch_pc_d = redirect_pc & ~32'h3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (replay) begin
                fetch_pc_d = pend_pc_q;
            end else if (issue) begin
                pend_pc_d  = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                data_d[wr_ptr_q] = mem_rdata;
                pc_d[wr_ptr_q]   = pend_pc_q;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // mem_req anticipates next cycle's credit check; redirect/replay cannot be foreseen.
        inflight_next = {1'b0, count_d} + {{CW{1'b0}}, pending_d};
        mem_req_d     = inflight_next < DEPTH_W;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            pending_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= NOP;
                pc_q[i]   <= 32'h0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
            mem_req_q  <= mem_req_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing scenarios plus a randomized run against a stream-level scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, inst_data, inst_pc;
    logic        mem_req, mem_rvalid, redirect_valid, inst_valid, inst_ready;

    logic [31:0] w_mem_addr, w_mem_rdata, w_inst_data, w_inst_pc;
    logic        w_mem_req, w_inst_valid;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] seg_q [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .mem_addr(w_mem_addr), .mem_req(w_mem_req),
        .mem_rdata(w_mem_rdata), .mem_rvalid(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .inst_ready(1'b1)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'hb700_0080;
            32'h0000_0004: rom = 32'h9700_0080;
            32'h0000_003C: rom = 32'h1300_0000;
            default:       rom = (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
        endcase
    endfunction

    // ROM models: one-cycle registered read of whatever address is presented.
    always @(posedge clk) begin
        mem_rdata   <= rom(mem_addr);
        w_mem_rdata <= rom(w_mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Releases reset so that the current cycle becomes cycle 0.
    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        mem_rvalid     = 1'b1;
        step(2);
        reset_n = 1'b1;
    endtask

    // Monitor: decode must see one contiguous PC stream per segment (reset or redirect).
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_pc = 32'h0;
        end else begin
            if (inst_valid && inst_ready) begin
                chk("stream_pc", inst_pc, exp_pc);
                chk("stream_data", inst_data, rom(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) begin
                if (seg_q.size() > 0) exp_pc = seg_q.pop_front();
                else chk("redirect_target_known", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        int start_cnt;
        reset_n        = 1'b0;
        inst_ready     = 1'b1;
        mem_rvalid     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step(2);

        // Reset state
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_inst_data", inst_data, 32'h13);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_wrap_addr", w_mem_addr, 32'hFFFF_FFF8);

        // Stream from reset, including the wrapping instance
        reset_n = 1'b1;
        chk("c0_mem_addr", mem_addr, 32'h0);
        step(1);
        chk("c1_inst_valid", 32'(inst_valid), 32'd0);
        step(1);
        chk("c2_inst_valid", 32'(inst_valid), 32'd1);
        chk("c2_inst_pc", inst_pc, 32'h0);
        chk("c2_inst_data", inst_data, 32'hb700_0080);
        chk("c2_wrap_pc", w_inst_pc, 32'hFFFF_FFF8);
        step(1);
        chk("c3_inst_pc", inst_pc, 32'h4);
        chk("c3_inst_data", inst_data, 32'h9700_0080);
        chk("c3_wrap_pc", w_inst_pc, 32'hFFFF_FFFC);
        step(1);
        chk("c4_wrap_pc", w_inst_pc, 32'h0);
        step(1);
        chk("c5_wrap_pc", w_inst_pc, 32'h4);
        for (int k = 0; k < 6; k++) begin
            chk("throughput_valid", 32'(inst_valid), 32'd1);
            chk("throughput_pc", inst_pc, 32'(12 + 4 * k));
            step(1);
        end

        // Backpressure: decode stalled for 10 cycles after reset
        inst_ready = 1'b0;
        do_reset();
        step(6);
        chk("bp_mem_req_c6", 32'(mem_req), 32'd0);
        step(3);
        chk("bp_mem_req_c9", 32'(mem_req), 32'd0);
        chk("bp_head_pc", inst_pc, 32'h0);
        chk("bp_fetch_addr", mem_addr, 32'h10);
        step(1);
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_valid", 32'(inst_valid), 32'd1);
            chk("bp_drain_pc", inst_pc, 32'(4 * k));
            step(1);
        end

        // Redirect to 0x3E coinciding with a push and a pop
        do_reset();
        step(5);
        chk("rd_pre_valid", 32'(inst_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3E;
        seg_q.push_back(32'h3C);
        step(1);
        redirect_valid = 1'b0;
        chk("rd_r1_valid", 32'(inst_valid), 32'd0);
        chk("rd_r1_addr", mem_addr, 32'h3C);
        chk("rd_r1_req", 32'(mem_req), 32'd1);
        step(1);
        chk("rd_r2_valid", 32'(inst_valid), 32'd0);
        step(1);
        chk("rd_r3_valid", 32'(inst_valid), 32'd1);
        chk("rd_r3_pc", inst_pc, 32'h3C);
        chk("rd_r3_data", inst_data, 32'h1300_0000);
        step(3);

        // Replay: ROM withholds valid for 3 cycles while 0x10 is in flight
        do_reset();
        step(5);
        mem_rvalid = 1'b0;
        step(1);
        chk("rp_c6_addr", mem_addr, 32'h10);
        step(1);
        chk("rp_c7_valid", 32'(inst_valid), 32'd0);
        step(1);
        mem_rvalid = 1'b1;
        chk("rp_c8_addr", mem_addr, 32'h10);
        step(2);
        chk("rp_c10_valid", 32'(inst_valid), 32'd1);
        chk("rp_c10_pc", inst_pc, 32'h10);
        step(3);

        // Asynchronous reset with three entries buffered
        inst_ready = 1'b0;
        do_reset();
        step(3);
        chk("ar_c3_req", 32'(mem_req), 32'd1);
        chk("ar_c3_addr", mem_addr, 32'hC);
        step(1);
        chk("ar_c4_valid", 32'(inst_valid), 32'd1);
        chk("ar_c4_addr", mem_addr, 32'h10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_now_valid", 32'(inst_valid), 32'd0);
        chk("ar_now_req", 32'(mem_req), 32'd0);
        chk("ar_now_addr", mem_addr, 32'h0);
        step(2);
        inst_ready = 1'b1;
        reset_n    = 1'b1;
        step(2);
        chk("ar_restart_valid", 32'(inst_valid), 32'd1);
        chk("ar_restart_pc", inst_pc, 32'h0);
        step(2);

        // Randomized traffic: stalls, ROM dropouts, redirects
        start_cnt = delivered;
        for (int n = 0; n < 3000; n++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                seg_q.push_back(redirect_pc & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
            step(1);
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        mem_rvalid     = 1'b1;
        step(10);
        chk("rand_liveness", 32'(delivered - start_cnt >= 800), 32'd1);
        chk("rand_seg_drained", 32'(seg_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
